// File: rtl/hazard_stall_ctrl_pkg.sv
// Shared constants and types for the pipeline hazard / stall controller.
// Holds the "operand not read" Tuse code, the default mult/div busy lengths
// and the mult/div sequencer state type.
package hazard_stall_ctrl_pkg;

    // Tuse value meaning the D-stage instruction does not read this operand.
    localparam logic [1:0] TUSE_NONE = 2'd3;

    // Default busy lengths of the HI/LO unit after a start in E.
    localparam int MULT_CYCLES_DEF = 5;
    localparam int DIV_CYCLES_DEF  = 10;

    // Mult/div sequencer state: IDLE <=> md_cnt == 0, BUSY <=> md_cnt != 0.
    typedef enum logic [0:0] {
        MD_IDLE = 1'b0,
        MD_BUSY = 1'b1
    } md_state_e;

endpackage : hazard_stall_ctrl_pkg

// File: rtl/hazard_stall_ctrl_md_busy_seq.sv
// Mult/div busy sequencer: loads a countdown when a mult/div enters E and
// counts it down to zero. The registered state doubles as md_busy.
module md_busy_seq
    import hazard_stall_ctrl_pkg::*;
#(
    parameter int MULT_CYCLES = MULT_CYCLES_DEF,
    parameter int DIV_CYCLES  = DIV_CYCLES_DEF,
    parameter int CNT_W       = 4
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start_i,
    input  logic             is_div_i,
    output logic [CNT_W-1:0] cnt_o,
    output md_state_e        state_o
);

    logic [CNT_W-1:0] cnt_q, cnt_d;
    md_state_e        state_q, state_d;

    // Next-state: load on a start while idle, otherwise count down while busy.
    // A start seen while busy is illegal upstream and is simply ignored.
    always_comb begin
        cnt_d   = cnt_q;
        state_d = state_q;
        case (state_q)
            MD_IDLE: begin
                if (start_i) begin
                    cnt_d = is_div_i ? CNT_W'(DIV_CYCLES) : CNT_W'(MULT_CYCLES);
                end
            end
            MD_BUSY: begin
                cnt_d = cnt_q - CNT_W'(1);
            end
            default: begin
                cnt_d = '0;
            end
        endcase
        state_d = (cnt_d != '0) ? MD_BUSY : MD_IDLE;
    end

    // State registers; reset abandons any countdown in flight.
    always_ff @(posedge clk) begin
        if (reset) begin
            cnt_q   <= '0;
            state_q <= MD_IDLE;
        end else begin
            cnt_q   <= cnt_d;
            state_q <= state_d;
        end
    end

    assign cnt_o   = cnt_q;
    assign state_o = state_q;

endmodule : md_busy_seq

// File: rtl/hazard_stall_ctrl.sv
// Hazard / stall controller for the 5-stage MIPS pipeline.
// Stalls D when a needed operand's producer in E or M will not be ready in
// time for forwarding (Tuse < Tnew), or when a HI/LO-class instruction in D
// meets a busy (or just-starting) mult/div unit. Stall freezes PC and F/D and
// inserts a bubble into D/E in the same cycle.
// Optional build macro: STALL_STATS_EN adds saturating stall_cycles and
// md_stall_cycles counters.
module hazard_stall_ctrl
    import hazard_stall_ctrl_pkg::*;
#(
    parameter int MULT_CYCLES = MULT_CYCLES_DEF,
    parameter int DIV_CYCLES  = DIV_CYCLES_DEF,
    parameter int CNT_W       = 4
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [4:0]       rsD,
    input  logic [4:0]       rtD,
    input  logic [1:0]       tuse_rsD,
    input  logic [1:0]       tuse_rtD,
    input  logic [4:0]       rt_rdE,
    input  logic [4:0]       rt_rdM,
    input  logic             regwE,
    input  logic             regwM,
    input  logic [2:0]       T_new_E,
    input  logic [2:0]       T_new_M,
    input  logic             md_startE,
    input  logic             md_is_divE,
    input  logic             md_useD,
    output logic             stall,
    output logic             enPC,
    output logic             enFD,
    output logic             flushDE,
    output logic             md_busy,
    output logic [CNT_W-1:0] md_cnt
`ifdef STALL_STATS_EN
    ,
    output logic [31:0]      stall_cycles,
    output logic [31:0]      md_stall_cycles
`endif
);

    logic      stall_rs, stall_rt, md_stall;
    md_state_e md_state;

    md_busy_seq #(
        .MULT_CYCLES (MULT_CYCLES),
        .DIV_CYCLES  (DIV_CYCLES),
        .CNT_W       (CNT_W)
    ) u_md_busy_seq (
        .clk      (clk),
        .reset    (reset),
        .start_i  (md_startE),
        .is_div_i (md_is_divE),
        .cnt_o    (md_cnt),
        .state_o  (md_state)
    );

    assign md_busy = (md_state == MD_BUSY);

    // Data hazard: an operand that is read, is not $0, and whose producer in
    // E or M needs more cycles than D can wait. Tuse is zero-extended.
    always_comb begin
        stall_rs = (tuse_rsD != TUSE_NONE) && (rsD != 5'd0) &&
                   ((rsD == rt_rdE && regwE && {1'b0, tuse_rsD} < T_new_E) ||
                    (rsD == rt_rdM && regwM && {1'b0, tuse_rsD} < T_new_M));
        stall_rt = (tuse_rtD != TUSE_NONE) && (rtD != 5'd0) &&
                   ((rtD == rt_rdE && regwE && {1'b0, tuse_rtD} < T_new_E) ||
                    (rtD == rt_rdM && regwM && {1'b0, tuse_rtD} < T_new_M));
    end

    // HI/LO hazard: the start cycle itself also blocks, since md_busy rises
    // only one edge later.
    assign md_stall = md_useD && (md_busy || md_startE);

    assign stall   = stall_rs | stall_rt | md_stall;
    assign enPC    = ~stall;
    assign enFD    = ~stall;
    assign flushDE = stall;

`ifdef STALL_STATS_EN
    logic [31:0] stall_cycles_q, stall_cycles_d;
    logic [31:0] md_stall_cycles_q, md_stall_cycles_d;

    // Saturating increments of the two stall statistics.
    always_comb begin
        stall_cycles_d    = stall_cycles_q;
        md_stall_cycles_d = md_stall_cycles_q;
        if (stall && stall_cycles_q != 32'hFFFF_FFFF) begin
            stall_cycles_d = stall_cycles_q + 32'd1;
        end
        if (md_stall && md_stall_cycles_q != 32'hFFFF_FFFF) begin
            md_stall_cycles_d = md_stall_cycles_q + 32'd1;
        end
    end

    // Statistics registers, cleared by reset.
    always_ff @(posedge clk) begin
        if (reset) begin
            stall_cycles_q    <= '0;
            md_stall_cycles_q <= '0;
        end else begin
            stall_cycles_q    <= stall_cycles_d;
            md_stall_cycles_q <= md_stall_cycles_d;
        end
    end

    assign stall_cycles    = stall_cycles_q;
    assign md_stall_cycles = md_stall_cycles_q;
`endif

endmodule : hazard_stall_ctrl

// File: tb/tb_hazard_stall_ctrl.sv
// Self-checking bench for hazard_stall_ctrl (default parameters).
// Build with +define+STALL_STATS_EN to also check the statistics counters.
module tb_hazard_stall_ctrl;

    localparam int CNT_W = 4;

    // ---------------- clock / reset ----------------
    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic             reset;
    logic [4:0]       rsD, rtD, rt_rdE, rt_rdM;
    logic [1:0]       tuse_rsD, tuse_rtD;
    logic             regwE, regwM;
    logic [2:0]       T_new_E, T_new_M;
    logic             md_startE, md_is_divE, md_useD;
    logic             stall, enPC, enFD, flushDE, md_busy;
    logic [CNT_W-1:0] md_cnt;
`ifdef STALL_STATS_EN
    logic [31:0]      stall_cycles, md_stall_cycles;
`endif

    hazard_stall_ctrl #(
        .MULT_CYCLES (5),
        .DIV_CYCLES  (10),
        .CNT_W       (CNT_W)
    ) dut (
        .clk         (clk),
        .reset       (reset),
        .rsD         (rsD),
        .rtD         (rtD),
        .tuse_rsD    (tuse_rsD),
        .tuse_rtD    (tuse_rtD),
        .rt_rdE      (rt_rdE),
        .rt_rdM      (rt_rdM),
        .regwE       (regwE),
        .regwM       (regwM),
        .T_new_E     (T_new_E),
        .T_new_M     (T_new_M),
        .md_startE   (md_startE),
        .md_is_divE  (md_is_divE),
        .md_useD     (md_useD),
        .stall       (stall),
        .enPC        (enPC),
        .enFD        (enFD),
        .flushDE     (flushDE),
        .md_busy     (md_busy),
        .md_cnt      (md_cnt)
`ifdef STALL_STATS_EN
        ,
        .stall_cycles    (stall_cycles),
        .md_stall_cycles (md_stall_cycles)
`endif
    );

    // ---------------- scoreboard state ----------------
    int          n_tests = 0;
    int          n_fail  = 0;
    logic [8:0]  exp_q[$];      // {stall, enPC, enFD, flushDE, md_busy, md_cnt}
    int          m_cnt   = 0;   // reference countdown
    logic [31:0] m_stall_cyc    = '0;
    logic [31:0] m_md_stall_cyc = '0;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_tests++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, obs, exp, $time);
        end
    endtask

    // Reference for one operand's data hazard.
    function automatic logic ref_port_stall(input logic [4:0] r, input logic [1:0] tu);
        if (tu == 2'd3 || r == 5'd0) return 1'b0;
        if (regwE && r == rt_rdE && int'(tu) < int'(T_new_E)) return 1'b1;
        if (regwM && r == rt_rdM && int'(tu) < int'(T_new_M)) return 1'b1;
        return 1'b0;
    endfunction

    // ---------------- driver tasks ----------------
    task automatic idle_inputs();
        rsD = 5'd0; rtD = 5'd0; tuse_rsD = 2'd3; tuse_rtD = 2'd3;
        rt_rdE = 5'd0; rt_rdM = 5'd0; regwE = 1'b0; regwM = 1'b0;
        T_new_E = 3'd0; T_new_M = 3'd0;
        md_startE = 1'b0; md_is_divE = 1'b0; md_useD = 1'b0;
    endtask

    // Inputs are already driven; predict, compare at negedge, advance model.
    task automatic tick();
        logic       dst, mst, st;
        logic [8:0] e;
        dst = ref_port_stall(rsD, tuse_rsD) | ref_port_stall(rtD, tuse_rtD);
        mst = md_useD && (m_cnt != 0 || md_startE);
        st  = dst | mst;
        exp_q.push_back({st, ~st, ~st, st, (m_cnt != 0), 4'(m_cnt)});
        @(negedge clk);
        e = exp_q.pop_front();
        check("stall",   32'(stall),   32'(e[8]));
        check("enPC",    32'(enPC),    32'(e[7]));
        check("enFD",    32'(enFD),    32'(e[6]));
        check("flushDE", 32'(flushDE), 32'(e[5]));
        check("md_busy", 32'(md_busy), 32'(e[4]));
        check("md_cnt",  32'(md_cnt),  32'(e[3:0]));
        if (md_startE) check("start_in_busy", 32'(md_busy), 32'd0);
`ifdef STALL_STATS_EN
        check("stall_cycles",    stall_cycles,    m_stall_cyc);
        check("md_stall_cycles", md_stall_cycles, m_md_stall_cyc);
`endif
        @(posedge clk);
        if (reset) begin
            m_cnt = 0; m_stall_cyc = '0; m_md_stall_cyc = '0;
        end else begin
            if (m_cnt != 0)     m_cnt = m_cnt - 1;
            else if (md_startE) m_cnt = md_is_divE ? 10 : 5;
            if (st  && m_stall_cyc    != 32'hFFFF_FFFF) m_stall_cyc++;
            if (mst && m_md_stall_cyc != 32'hFFFF_FFFF) m_md_stall_cyc++;
        end
        #1;
    endtask

    // ---------------- stimulus ----------------
    initial begin
        reset = 1'b1;
        idle_inputs();
        @(posedge clk); #1;
        tick();                       // reset state, idle inputs
        reset = 1'b0;
        tick();

        // lw $1 in E, D reads rs=1 at tuse 1: stall.
        rt_rdE = 5'd1; regwE = 1'b1; T_new_E = 3'd2; rsD = 5'd1; tuse_rsD = 2'd1;
        tick();
        // Same producer now in M with T_new 1: no stall.
        rt_rdE = 5'd0; regwE = 1'b0; T_new_E = 3'd0;
        rt_rdM = 5'd1; regwM = 1'b1; T_new_M = 3'd1;
        tick();
        // $0 never stalls.
        idle_inputs();
        rt_rdE = 5'd0; regwE = 1'b1; T_new_E = 3'd1; rsD = 5'd0; tuse_rsD = 2'd0;
        tick();
        // Operand not read never stalls.
        rt_rdE = 5'd4; rsD = 5'd4; tuse_rsD = 2'd3;
        tick();
        // rt path through M.
        idle_inputs();
        rtD = 5'd5; tuse_rtD = 2'd0; rt_rdM = 5'd5; regwM = 1'b1; T_new_M = 3'd1;
        tick();
        // Matching index but producer does not write: no stall.
        regwM = 1'b0;
        tick();

        // mult start with mflo in D from the start cycle.
        idle_inputs();
        md_startE = 1'b1; md_is_divE = 1'b0; md_useD = 1'b1;
        tick();
        md_startE = 1'b0;
        repeat (6) tick();

        // div start; unrelated add in D is never stalled.
        idle_inputs();
        md_startE = 1'b1; md_is_divE = 1'b1;
        tick();
        md_startE = 1'b0; md_is_divE = 1'b0;
        rsD = 5'd2; rtD = 5'd3; tuse_rsD = 2'd1; tuse_rtD = 2'd1;
        repeat (11) tick();

        // Reset mid-countdown at md_cnt=7 with mfhi in D.
        idle_inputs();
        md_startE = 1'b1; md_is_divE = 1'b1;
        tick();
        md_startE = 1'b0; md_is_divE = 1'b0;
        repeat (3) tick();
        md_useD = 1'b1; reset = 1'b1;
        tick();
        reset = 1'b0;
        repeat (2) tick();

        // Combined: 3 data-stall cycles then a mult with HI/LO use in D.
        idle_inputs();
        rt_rdE = 5'd7; regwE = 1'b1; T_new_E = 3'd2; rsD = 5'd7; tuse_rsD = 2'd0;
        repeat (3) tick();
        idle_inputs();
        md_startE = 1'b1; md_useD = 1'b1;
        tick();
        md_startE = 1'b0;
        repeat (5) tick();
        md_useD = 1'b0;
        tick();

        // Randomised traffic over a small register space.
        for (int i = 0; i < 400; i++) begin
            reset      = ($urandom_range(0, 59) == 0);
            rsD        = 5'($urandom_range(0, 3));
            rtD        = 5'($urandom_range(0, 3));
            tuse_rsD   = 2'($urandom_range(0, 3));
            tuse_rtD   = 2'($urandom_range(0, 3));
            rt_rdE     = 5'($urandom_range(0, 3));
            rt_rdM     = 5'($urandom_range(0, 3));
            regwE      = 1'($urandom_range(0, 1));
            regwM      = 1'($urandom_range(0, 1));
            T_new_E    = 3'($urandom_range(0, 3));
            T_new_M    = 3'($urandom_range(0, 2));
            md_startE  = (m_cnt == 0) && ($urandom_range(0, 5) == 0);
            md_is_divE = 1'($urandom_range(0, 1));
            md_useD    = 1'($urandom_range(0, 1));
            tick();
        end

        // Final reset clears everything.
        idle_inputs();
        reset = 1'b1;
        tick();
        reset = 1'b0;
        tick();

        check("exp_q_empty", 32'(exp_q.size()), 32'd0);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

    // Global time limit so the run always ends.
    initial begin
        #200000;
        $display("FAIL timeout: simulation exceeded time limit");
        $fatal(1, "timeout");
    end

endmodule : tb_hazard_stall_ctrl

// File: doc/hazard_stall_ctrl.md
Name: hazard_stall_ctrl

Overview:
- Pipeline hazard controller for the 5-stage MIPS core; sits beside the forwarding unit and decides when the D stage must be held.
- Compares D-stage operand use time (Tuse) against producer ready time (Tnew) in E and M, and stalls when forwarding cannot cover the gap.
- Owns the multiply/divide busy sequencer: a countdown that blocks HI/LO-class instructions in D while mult/div is in flight.
- Drives PC/FD enables and the D/E flush (bubble insert).

Parameters:
MULT_CYCLES, 5, busy cycles after a mult/multu start
DIV_CYCLES, 10, busy cycles after a div/divu start
CNT_W, 4, countdown width; must hold max(MULT_CYCLES, DIV_CYCLES)

Ports:
clk  in  1  clock
reset  in  1  synchronous, active-high reset
rsD  in  5  D-stage rs index
rtD  in  5  D-stage rt index
tuse_rsD  in  2  cycles until rs is needed (0..2; 3 = not read)
tuse_rtD  in  2  cycles until rt is needed (0..2; 3 = not read)
rt_rdE  in  5  E-stage destination register
rt_rdM  in  5  M-stage destination register
regwE  in  1  E-stage instruction writes the register file
regwM  in  1  M-stage instruction writes the register file
T_new_E  in  3  cycles until E-stage result is forwardable
T_new_M  in  3  cycles until M-stage result is forwardable
md_startE  in  1  mult/div instruction is in E this cycle
md_is_divE  in  1  with md_startE: 1 = div/divu, 0 = mult/multu
md_useD  in  1  D instruction is mult/div/mfhi/mflo/mthi/mtlo
stall  out  1  hold D stage
enPC  out  1  PC write enable (= ~stall)
enFD  out  1  F/D register enable (= ~stall)
flushDE  out  1  load bubble into D/E (= stall)
md_busy  out  1  mult/div sequencer active
md_cnt  out  CNT_W  remaining busy cycles

Behaviour:
- Data stall, combinational. stall_rs = tuse_rsD!=3 && rsD!=0 && ((rsD==rt_rdE && regwE && tuse_rsD<T_new_E) || (rsD==rt_rdM && regwM && tuse_rsD<T_new_M)). stall_rt is the same with rtD/tuse_rtD. Comparisons are unsigned; tuse is zero-extended to 3 bits.
- MD sequencer FSM states:
  - IDLE (md_cnt==0).
  - BUSY (md_cnt!=0).
  - IDLE -> BUSY when md_startE=1: md_cnt loads DIV_CYCLES if md_is_divE, else MULT_CYCLES.
  - In BUSY, md_cnt decrements by 1 each cycle. The transition 1 -> 0 returns to IDLE.
  - md_startE in BUSY is ignored (cannot occur legally). The bench flags it as an error.
- md_busy = (md_cnt!=0), registered.
- md_stall = md_useD && (md_busy || md_startE).
- stall = stall_rs | stall_rt | md_stall.
- enPC = enFD = ~stall; flushDE = stall. These are combinational, with no added latency.
- Latency: a start in cycle t gives md_busy=1 for cycles t+1 .. t+N. The first D-stage HI/LO-class instruction proceeds in cycle t+N+1.
- Reset: md_cnt=0 and md_busy=0. Reset asserted mid-operation abandons the countdown on the next edge.
- Reset outputs once inputs are idle: stall=0, enPC=1, enFD=1, flushDE=0.
- Simultaneous data stall and md_stall: a single stall; both conditions are simply OR'd.

Optional Feature:
- Macro STALL_STATS_EN.
- With the macro defined:
  - Extra output stall_cycles[31:0]: counts cycles with stall=1.
  - Extra output md_stall_cycles[31:0]: counts cycles with md_stall=1.
  - Both counters clear on reset and saturate at 32'hFFFFFFFF.
- Without the macro: the ports and counters are absent, and all other behaviour is identical.

Decomposition:
- Shared package holds:
  - TUSE_NONE = 2'd3.
  - Default MULT_CYCLES and DIV_CYCLES constants.
  - The md sequencer state typedef (IDLE, BUSY).
- One natural sub-module: md_busy_seq (countdown plus md_busy), instantiated once. The hazard compare stays in the parent.

Test Plan:
- lw $1 in E (T_new_E=2, rt_rdE=1, regwE=1); D reads rs=1 with tuse_rsD=1 -> stall=1, enPC=0, flushDE=1. Next cycle, with the same producer in M (T_new_M=1) -> stall=0.
- rsD=0 with a matching E write and tuse=0 < T_new_E=1 -> stall=0. Likewise tuse_rsD=3 -> stall=0.
- md_startE=1, md_is_divE=0 at cycle t; mflo in D from t -> stall=1 during t..t+5. md_cnt reads 5,4,3,2,1 over t+1..t+5; stall=0 at t+6.
- div start (md_is_divE=1) -> md_cnt=10 next cycle and md_busy high for 10 cycles. An unrelated add in D is never stalled.
- reset=1 when md_cnt=7 -> md_cnt=0 and md_busy=0 after the edge, and mfhi in D is no longer stalled.
- STALL_STATS_EN: 3 data-stall cycles plus 5 md-stall cycles -> stall_cycles=8, md_stall_cycles=5. Reset clears both.
